memory_stage: RTL and testbench

- MEM pipeline stage; consumes the EX-stage outputs (ALU result, store data, write-register index, control bits) through its own E->M pipeline register.
- Performs word loads/stores over the split-handshake data bus (valid/addr_ok/data_ok).
- Returns ALUOutM to EX as the M-stage forwarding source, and raises a stall request to the hazard unit while an access is outstanding.

---
 rtl/memory_stage_pkg.sv | 38 +++
 rtl/memory_stage_min.sv | 24 ++
 rtl/memory_stage.sv | 175 +++++++++++++++++
 tb/tb_memory_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package memory_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;
    typedef logic [4:0]  regidx_t;

    // Bus-side access state of the MEM stage.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } mem_state_t;

    localparam logic [3:0] STROBE_WORD = 4'b1111;
    localparam logic [3:0] STROBE_NONE = 4'b0000;

    // Link address is reported as PC + 8 (delay slot skipped); fixed, informational.
    localparam word_t LINK_OFFSET = 32'd8;

    // Contents of the E->M pipeline register.
    typedef struct packed {
        addr_t   pc;
        word_t   aluOut;
        word_t   writeData;
        regidx_t writeReg;
        logic    regWrite;
        logic    memtoReg;
        logic    memWrite;
    } stage_em_t;

    function automatic addr_t linkAddr(input addr_t pc);
        return pc + LINK_OFFSET;
    endfunction

endpackage

// File: rtl/memory_stage_min.sv
// E->M pipeline register: flush loads a bubble, stall holds, otherwise loads the E values.
module memory_stage_min
    import memory_stage_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      StallM,
    input  logic      FlushM,
    input  stage_em_t dIn,
    output stage_em_t qOut
);

    // Stage register; flush wins over stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            qOut <= '0;
        end else if (FlushM) begin
            qOut <= '0;
        end else if (!StallM) begin
            qOut <= dIn;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: E->M register plus the word load/store engine on the split-handshake
// data bus. Optional misaligned-access check is enabled by defining MEM_ALIGN_CHECK_EN.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        StallM,
    input  logic        FlushM,
    input  addr_t       PCE,
    input  word_t       ALUOutE,
    input  word_t       WriteDataE,
    input  regidx_t     WriteRegE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    output addr_t       PCM,
    output word_t       ALUOutM,
    output regidx_t     WriteRegM,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output word_t       ReadDataM,
    output logic        MemStallM,
    output logic        dreq_valid,
    output addr_t       dreq_addr,
    output logic [3:0]  dreq_strobe,
    output word_t       dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  word_t       dresp_data,
    output logic        ExcM
);

    stage_em_t  eIn;
    stage_em_t  mReg;
    mem_state_t stateQ, stateD;
    logic       needAddrQ, needAddrD;
    addr_t      holdAddrQ;
    word_t      holdDataQ;
    logic [3:0] holdStrobeQ;
    word_t      readDataQ;
    logic       memop;
    logic       alignErr;
    logic       issue;
    logic       reqValid;
    logic       capture;
    logic [3:0] strobeCur;

    assign eIn = '{pc: PCE, aluOut: ALUOutE, writeData: WriteDataE, writeReg: WriteRegE,
                   regWrite: RegWriteE, memtoReg: MemtoRegE, memWrite: MemWriteE};

    memory_stage_min u_min (
        .clk    (clk),
        .resetn (resetn),
        .StallM (StallM),
        .FlushM (FlushM),
        .dIn    (eIn),
        .qOut   (mReg)
    );

    assign memop     = mReg.memtoReg | mReg.memWrite;
    assign strobeCur = mReg.memWrite ? STROBE_WORD : STROBE_NONE;

`ifdef MEM_ALIGN_CHECK_EN
    assign alignErr = memop & (mReg.aluOut[1:0] != 2'b00);
`else
    assign alignErr = 1'b0;
`endif

    assign issue = memop & ~alignErr;

    // Next-state logic; IDLE with a pending op behaves as REQ in the same cycle.
    always_comb begin
        stateD    = stateQ;
        needAddrD = needAddrQ;
        reqValid  = 1'b0;
        capture   = 1'b0;
        unique case (stateQ)
            IDLE, REQ: begin
                reqValid = (stateQ == REQ) | issue;
                if (reqValid) begin
                    if (dresp_addr_ok && dresp_data_ok) begin
                        stateD  = FlushM ? IDLE : DONE;
                        capture = mReg.memtoReg & ~FlushM;
                    end else if (dresp_addr_ok) begin
                        stateD    = FlushM ? DRAIN : WAIT;
                        needAddrD = 1'b0;
                    end else begin
                        // A flushed request must still be held until accepted.
                        stateD    = FlushM ? DRAIN : REQ;
                        needAddrD = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (dresp_data_ok) begin
                    stateD  = FlushM ? IDLE : DONE;
                    capture = mReg.memtoReg & ~FlushM;
                end else if (FlushM) begin
                    stateD    = DRAIN;
                    needAddrD = 1'b0;
                end
            end
            DONE: begin
                if (FlushM || !StallM) begin
                    stateD = IDLE;
                end
            end
            DRAIN: begin
                reqValid = needAddrQ;
                if (needAddrQ) begin
                    if (dresp_addr_ok) begin
                        needAddrD = 1'b0;
                        if (dresp_data_ok) begin
                            stateD = IDLE;
                        end
                    end
                end else if (dresp_data_ok) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // FSM state and drain bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ    <= IDLE;
            needAddrQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            needAddrQ <= needAddrD;
        end
    end

    // Snapshot of the live request so a drained access keeps stable bus fields after flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            holdAddrQ   <= '0;
            holdDataQ   <= '0;
            holdStrobeQ <= STROBE_NONE;
        end else if (stateQ != DRAIN) begin
            holdAddrQ   <= mReg.aluOut;
            holdDataQ   <= mReg.writeData;
            holdStrobeQ <= strobeCur;
        end
    end

    // Load data capture on the completing data_ok of a live load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            readDataQ <= '0;
        end else if (capture) begin
            readDataQ <= dresp_data;
        end
    end

    // Stage and bus outputs.
    always_comb begin
        PCM         = mReg.pc;
        ALUOutM     = mReg.aluOut;
        WriteRegM   = mReg.writeReg;
        RegWriteM   = mReg.regWrite & ~alignErr;
        MemtoRegM   = mReg.memtoReg;
        ReadDataM   = readDataQ;
        ExcM        = alignErr;
        MemStallM   = (issue & (stateQ != DONE)) | (stateQ == DRAIN);
        dreq_valid  = reqValid;
        dreq_addr   = (stateQ == DRAIN) ? holdAddrQ : mReg.aluOut;
        dreq_data   = (stateQ == DRAIN) ? holdDataQ : mReg.writeData;
        dreq_strobe = (stateQ == DRAIN) ? holdStrobeQ : strobeCur;
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized ops against a
// transaction-level expectation (request/stall cycle counts from bus latencies).
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       StallM;
    logic       FlushM = 1'b0;
    word_t      PCE, ALUOutE, WriteDataE;
    regidx_t    WriteRegE;
    logic       RegWriteE, MemtoRegE, MemWriteE;
    word_t      PCM, ALUOutM, ReadDataM, dreq_addr, dreq_data, dresp_data;
    regidx_t    WriteRegM;
    logic       RegWriteM, MemtoRegM, MemStallM, dreq_valid, ExcM;
    logic [3:0] dreq_strobe;
    logic       dresp_addr_ok = 1'b0;
    logic       dresp_data_ok = 1'b0;

    int    tests = 0;
    int    fails = 0;
    word_t expRead = '0;

    // Hazard unit stand-in: M holds while the stage asks for a stall.
    assign StallM = MemStallM;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .StallM        (StallM),
        .FlushM        (FlushM),
        .PCE           (PCE),
        .ALUOutE       (ALUOutE),
        .WriteDataE    (WriteDataE),
        .WriteRegE     (WriteRegE),
        .RegWriteE     (RegWriteE),
        .MemtoRegE     (MemtoRegE),
        .MemWriteE     (MemWriteE),
        .PCM           (PCM),
        .ALUOutM       (ALUOutM),
        .WriteRegM     (WriteRegM),
        .RegWriteM     (RegWriteM),
        .MemtoRegM     (MemtoRegM),
        .ReadDataM     (ReadDataM),
        .MemStallM     (MemStallM),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .ExcM          (ExcM)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic driveE(input word_t pc, input word_t alu, input word_t wd, input regidx_t wr,
                          input logic rw, input logic m2r, input logic mw);
        PCE = pc; ALUOutE = alu; WriteDataE = wd; WriteRegE = wr;
        RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw;
    endtask

    task automatic bubble();
        driveE('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkMZero(input string tag);
        check({tag, ".pc"}, PCM, 0);
        check({tag, ".alu"}, ALUOutM, 0);
        check({tag, ".wreg"}, WriteRegM, 0);
        check({tag, ".rw"}, RegWriteM, 0);
        check({tag, ".m2r"}, MemtoRegM, 0);
    endtask

    // Non-memory op: visible in M one cycle later, no stall, no request.
    task automatic aluOp(input word_t pc, input word_t alu, input regidx_t wr, input logic rw);
        driveE(pc, alu, $urandom, wr, rw, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bubble();
        check("alu.pc", PCM, pc);
        check("alu.out", ALUOutM, alu);
        check("alu.wreg", WriteRegM, wr);
        check("alu.rw", RegWriteM, rw);
        check("alu.stall", MemStallM, 0);
        check("alu.valid", dreq_valid, 0);
    endtask

    // Memory op with addr_ok `a` cycles after the first request cycle and data_ok `d` cycles
    // after addr_ok. Expect a+1 request cycles and a+d+1 stall cycles; flushAt<0 means none.
    task automatic memOp(input logic isStore, input word_t pc, input word_t addr,
                         input word_t wdata, input regidx_t wr, input word_t rdata,
                         input int a, input int d, input int flushAt);
        int valids = 0;
        int stalls = 0;
        int k = 0;
        bit done = 0;
        driveE(pc, addr, wdata, wr, !isStore, !isStore, isStore);
        @(posedge clk);
        @(negedge clk);
        bubble();
        check("mem.pc", PCM, pc);
        check("mem.alu", ALUOutM, addr);
        check("mem.wreg", WriteRegM, wr);
        check("mem.m2r", MemtoRegM, !isStore);
        check("mem.exc", ExcM, 0);
        check("mem.first", dreq_valid, 1);
        while (!done) begin
            if (dreq_valid) begin
                valids++;
                check("req.addr", dreq_addr, addr);
                check("req.strobe", dreq_strobe, isStore ? 32'hF : 32'h0);
                if (isStore) check("req.data", dreq_data, wdata);
            end
            if (MemStallM) stalls++;
            if (!MemStallM) begin
                done = 1;
            end else if (k > 40) begin
                check("mem.timeout", k, 0);
                done = 1;
            end else begin
                dresp_addr_ok = (k == a);
                dresp_data_ok = (k == a + d);
                dresp_data    = (k == a + d) ? rdata : $urandom;
                FlushM        = (k == flushAt);
                @(posedge clk);
                @(negedge clk);
                dresp_addr_ok = 1'b0;
                dresp_data_ok = 1'b0;
                FlushM        = 1'b0;
                if (k == flushAt) checkMZero("flush");
                k++;
            end
        end
        check("mem.valids", valids, a + 1);
        check("mem.stalls", stalls, a + d + 1);
        check("mem.endvalid", dreq_valid, 0);
        if (flushAt >= 0) begin
            check("drain.alu", ALUOutM, 0);
        end else begin
            check("done.alu", ALUOutM, addr);
            check("done.rw", RegWriteM, !isStore);
            if (!isStore) expRead = rdata;
        end
        check("mem.rdata", ReadDataM, expRead);
    endtask

    initial begin
        bubble();
        dresp_data = '0;
        #1 resetn = 1'b0;
        #1;
        checkMZero("reset");
        check("reset.rdata", ReadDataM, 0);
        check("reset.stall", MemStallM, 0);
        check("reset.valid", dreq_valid, 0);
        check("reset.exc", ExcM, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        aluOp(32'h100, 32'h1234, 5'd8, 1'b1);
        memOp(1'b0, 32'h104, 32'h8000_0010, 32'h0, 5'd9, 32'hDEAD_BEEF, 0, 0, -1);
        aluOp(32'h108, 32'h55AA, 5'd3, 1'b0);
        memOp(1'b1, 32'h10C, 32'h8000_0020, 32'hCAFE_F00D, 5'd0, 32'h0, 2, 3, -1);
        // Flush while waiting for data: returned data is dropped.
        memOp(1'b0, 32'h110, 32'h8000_0030, 32'h0, 5'd4, 32'h1111_2222, 1, 3, 2);
        // Flush while the request is still unaccepted.
        memOp(1'b1, 32'h114, 32'h8000_0034, 32'h7777_8888, 5'd0, 32'h0, 3, 1, 1);
        // Back-to-back loads: second request issues right after the DONE cycle.
        memOp(1'b0, 32'h118, 32'h8000_0040, 32'h0, 5'd5, 32'hA5A5_0001, 1, 0, -1);
        memOp(1'b0, 32'h11C, 32'h8000_0044, 32'h0, 5'd6, 32'hA5A5_0002, 0, 1, -1);

`ifdef MEM_ALIGN_CHECK_EN
        driveE(32'h120, 32'h8000_0012, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bubble();
        check("align.exc", ExcM, 1);
        check("align.rw", RegWriteM, 0);
        check("align.valid", dreq_valid, 0);
        check("align.stall", MemStallM, 0);
        @(posedge clk);
        @(negedge clk);
        check("align.clear", ExcM, 0);
`else
        memOp(1'b0, 32'h120, 32'h8000_0012, 32'h0, 5'd7, 32'h0BAD_0002, 1, 1, -1);
`endif

        for (int i = 0; i < 40; i++) begin
            int kind = $urandom_range(0, 2);
            int a = $urandom_range(0, 3);
            int d = $urandom_range(0, 3);
            int fl = -1;
            word_t addr = $urandom & 32'hFFFF_FFFC;
            if ((a + d) > 0 && ($urandom_range(0, 2) == 0)) fl = $urandom_range(0, a + d - 1);
            if (kind == 0) aluOp($urandom, $urandom, regidx_t'($urandom), 1'($urandom));
            else memOp(kind == 2, $urandom, addr, $urandom, regidx_t'($urandom), $urandom,
                       a, d, fl);
        end

        // Asynchronous reset while a request is pending.
        driveE(32'h200, 32'h8000_0050, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bubble();
        check("areset.pre", dreq_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("areset.valid", dreq_valid, 0);
        check("areset.stall", MemStallM, 0);
        check("areset.rdata", ReadDataM, 0);
        check("areset.exc", ExcM, 0);
        checkMZero("areset");
        expRead = '0;
        @(negedge clk);
        resetn = 1'b1;
        aluOp(32'h204, 32'h4321, 5'd31, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
